// File: rtl/multisim_rw_pkg.sv
// rtl/multisim_rw_pkg.sv - shared types and widths for the multisim read/write channel
package multisim_rw_pkg;

    localparam int RW_WORD_W = 64;
    localparam int RW_CMD_W  = 3 * RW_WORD_W;
    localparam int RW_RSP_W  = 64;

    localparam logic [RW_WORD_W-1:0] RW_OP_WRITE = 64'd0;
    localparam logic [RW_WORD_W-1:0] RW_OP_READ  = 64'd1;

    typedef struct packed {
        logic [RW_WORD_W-1:0] wdata;
        logic [RW_WORD_W-1:0] addr;
        logic [RW_WORD_W-1:0] op;
    } rw_cmd_t;

    typedef logic [RW_RSP_W-1:0] rw_rsp_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/multisim_rw_arbiter_if.sv
// rtl/multisim_rw_arbiter_if.sv - requester-side and channel-side signals of the rw arbiter
interface multisim_rw_arbiter_if #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 4
);
    import multisim_rw_pkg::*;

    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [NUM_REQ-1:0]          req_cmd_vld;
    logic [NUM_REQ-1:0]          req_cmd_rdy;
    logic [NUM_REQ*RW_CMD_W-1:0] req_cmd;
    logic [NUM_REQ-1:0]          req_rsp_vld;
    logic [NUM_REQ-1:0]          req_rsp_rdy;
    logic [RW_RSP_W-1:0]         req_rsp;
    logic                        cmd_vld;
    logic                        cmd_rdy;
    logic [RW_CMD_W-1:0]         cmd;
    logic                        rsp_vld;
    logic                        rsp_rdy;
    logic [RW_RSP_W-1:0]         rsp;
    logic [OUT_W-1:0]            outstanding;
    logic                        err_unexpected_rsp;

    modport master (
        input  req_cmd_vld, req_cmd, req_rsp_rdy, cmd_rdy, rsp_vld, rsp,
        output req_cmd_rdy, req_rsp_vld, req_rsp, cmd_vld, cmd, rsp_rdy,
               outstanding, err_unexpected_rsp
    );

    modport slave (
        output req_cmd_vld, req_cmd, req_rsp_rdy, cmd_rdy, rsp_vld, rsp,
        input  req_cmd_rdy, req_rsp_vld, req_rsp, cmd_vld, cmd, rsp_rdy,
               outstanding, err_unexpected_rsp
    );

endinterface

// File: rtl/multisim_rw_id_fifo.sv
// rtl/multisim_rw_id_fifo.sv - synchronous FIFO holding requester IDs of in-flight commands
module multisim_rw_id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/multisim_rw_arbiter.sv
// rtl/multisim_rw_arbiter.sv - round-robin sharing of one rw command/response channel pair
module multisim_rw_arbiter
    import multisim_rw_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multisim_rw_arbiter_if.master bus
);

    localparam int IDW   = $clog2(NUM_REQ);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_e       state_q;
    arb_state_e       state_d;
    rw_cmd_t          cmd_q;
    rw_cmd_t          cmd_sel;
    logic [IDW-1:0]   last_grant_q;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   head_id;
    logic             grant_found;
    logic             slot_free;
    logic             accept;
    logic             rsp_rdy;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [OUT_W-1:0] fifo_count;
    logic             err_q;

    // First valid requester at or after last_grant+1, wrapping modulo NUM_REQ.
    always_comb begin
        int             idx;
        logic [IDW-1:0] idx_w;
        grant_id    = '0;
        grant_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx   = (int'(last_grant_q) + k) % NUM_REQ;
            idx_w = IDW'(idx);
            if (!grant_found && bus.req_cmd_vld[idx_w]) begin
                grant_found = 1'b1;
                grant_id    = idx_w;
            end
        end
    end

    always_comb begin
        cmd_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDW'(i)) cmd_sel = bus.req_cmd[i*RW_CMD_W +: RW_CMD_W];
        end
    end

    // The slot reloads on the handshake cycle, giving one command per cycle.
    assign slot_free = (state_q == ARB_IDLE) || bus.cmd_rdy;
    assign accept    = slot_free && !fifo_full && grant_found;

    always_comb begin
        bus.req_cmd_rdy = '0;
        if (accept) bus.req_cmd_rdy[grant_id] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (accept) state_d = ARB_HOLD;
            ARB_HOLD: if (bus.cmd_rdy) state_d = accept ? ARB_HOLD : ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            cmd_q        <= '0;
            last_grant_q <= IDW'(NUM_REQ - 1);
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cmd_q        <= cmd_sel;
                last_grant_q <= grant_id;
            end
            if (bus.rsp_vld && fifo_empty) err_q <= 1'b1;
        end
    end

    assign bus.cmd_vld = (state_q == ARB_HOLD);
    assign bus.cmd     = cmd_q;

    multisim_rw_id_fifo #(
        .WIDTH (IDW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .wdata (grant_id),
        .pop   (pop),
        .rdata (head_id),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Responses return in issue order; the head requester alone may take the current one.
    always_comb begin
        bus.req_rsp_vld = '0;
        if (bus.rsp_vld && !fifo_empty) bus.req_rsp_vld[head_id] = 1'b1;
    end

    assign rsp_rdy                = !fifo_empty && bus.req_rsp_rdy[head_id];
    assign pop                    = bus.rsp_vld && rsp_rdy;
    assign bus.rsp_rdy            = rsp_rdy;
    assign bus.req_rsp            = bus.rsp;
    assign bus.outstanding        = fifo_count;
    assign bus.err_unexpected_rsp = err_q;

endmodule

// File: doc/multisim_rw_arbiter.md
# multisim_rw_arbiter

- Shares one multisim read/write command channel (push client, 192-bit `{wdata, addr, op}`) and its response channel (pull client, 64-bit) between `NUM_REQ` independent requesters.
- Sits between the testbench-side requester tasks/agents and the `rw_cmd` / `rw_rsp` client instances.
- Grants commands round-robin and remembers the issuing requester of every in-flight command.
- Routes each response, in order, back to the requester that issued the command.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters, 2..16.
- `MAX_OUTSTANDING`, 4: depth of the in-flight requester-ID FIFO, power of two, ≥2.

Ports:
- `clk`  in  1: single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_cmd_vld`  in  `NUM_REQ`: per-requester command valid.
- `req_cmd_rdy`  out  `NUM_REQ`: per-requester command accept, one-hot or zero.
- `req_cmd`  in  `NUM_REQ*192`: requester i occupies bits `[i*192 +: 192]`.
- `req_rsp_vld`  out  `NUM_REQ`: per-requester response valid, one-hot or zero.
- `req_rsp_rdy`  in  `NUM_REQ`: per-requester response ready.
- `req_rsp`  out  64: response data, broadcast to all requesters.
- `cmd_vld`  out  1: to the push client `data_vld`.
- `cmd_rdy`  in  1: from the push client `data_rdy`.
- `cmd`  out  192: to the push client `data`.
- `rsp_vld`  in  1: from the pull client `data_vld`.
- `rsp_rdy`  out  1: to the pull client `data_rdy`.
- `rsp`  in  64: from the pull client `data`.
- `outstanding`  out  `$clog2(MAX_OUTSTANDING)+1`: number of in-flight commands.
- `err_unexpected_rsp`  out  1: sticky; set when a response arrives with nothing in flight.

## Operation

Command path:
- A one-entry output register holds `cmd`/`cmd_vld`. The slot is free when `cmd_vld==0`, or when `cmd_vld && cmd_rdy` in the current cycle.
- Accept condition: slot free, ID FIFO not full, and at least one `req_cmd_vld` set.
  - The round-robin pointer selects the first valid requester at or after `last_grant+1`, wrapping modulo `NUM_REQ`.
  - `req_cmd_rdy[g]=1` combinationally in that cycle.
  - On the next edge: `cmd` loads `req_cmd[g]`, `cmd_vld` is set, `g` is pushed into the ID FIFO, and `last_grant` becomes `g`.
- `cmd` and `cmd_vld` stay stable while `cmd_vld && !cmd_rdy`.
- Every command, read or write, produces exactly one response.

Response path, combinational pass-through:
- `h` = ID at the FIFO head.
- `req_rsp_vld[h] = rsp_vld && !fifo_empty`.
- `rsp_rdy = !fifo_empty && req_rsp_rdy[h]`.
- `req_rsp = rsp`.
- On `rsp_vld && rsp_rdy`, the head is popped.

FIFO occupancy:
- `outstanding` is the FIFO occupancy: incremented on accept, decremented on pop.
- Accept and pop in the same cycle leaves it unchanged.

Boundary conditions:
- FIFO full: no accept, even if a pop occurs in the same cycle (no bypass).
- FIFO empty and `rsp_vld=1`:
  - `rsp_rdy=0`.
  - `err_unexpected_rsp` is set on the next edge and cleared only by reset.
- Requester drops `req_cmd_vld` before acceptance: no state change; arbitration is recomputed every cycle.
- Responses never reorder. A head requester that holds `req_rsp_rdy=0` blocks all responses.
- Reset mid-operation:
  - All state clears immediately.
  - In-flight IDs are lost; later responses flag `err_unexpected_rsp`.
  - `last_grant` resets to `NUM_REQ-1`, so requester 0 has first priority.

## Timing

- Reset values: `cmd_vld=0`, `cmd=0`, `req_cmd_rdy=0`, `req_rsp_vld=0`, `req_rsp=rsp`, `rsp_rdy=0`, `outstanding=0`, `err_unexpected_rsp=0`.
- Requester accept → `cmd_vld` high: 1 cycle.
- Sustained throughput: one command per cycle when `cmd_rdy` is held high and the FIFO is not full, because the slot reloads on the handshake cycle.
- Response latency through the block: 0 cycles.
- Arbitration state machine:
  - IDLE (`cmd_vld=0`) → HOLD on accept.
  - HOLD → HOLD on handshake with a new accept, otherwise stay while `!cmd_rdy`.
  - HOLD → IDLE on handshake without a new accept.

## Structure

- Package `multisim_rw_pkg`:
  - `RW_OP_WRITE=0`, `RW_OP_READ=1`.
  - `RW_WORD_W=64`, `RW_CMD_W=3*64`, `RW_RSP_W=64`.
  - Typedefs `rw_cmd_t` (packed struct `{wdata, addr, op}`) and `rw_rsp_t`.
- Sub-module `multisim_rw_id_fifo`:
  - Synchronous FIFO with parameters `WIDTH` and `DEPTH`.
  - Ports: `push`, `pop`, `full`, `empty`, `count`.
  - Same `clk`/`rst_n` as the parent.

## Test plan

- Single requester 0 writes addr 0x5, wdata 0xbebecacadeadb00b, then reads addr 0x5, with the server echoing: `cmd` = {0xbebecacadeadb00b, 0x5, 0} then {x, 0x5, 1}; two responses, both returned only on `req_rsp_vld[0]`; `outstanding` returns to 0.
- All four requesters valid every cycle, `cmd_rdy=1`, `MAX_OUTSTANDING=4`, responses withheld: grants in order 0,1,2,3; the fifth accept is blocked with `outstanding=4`; after one response, the next grant is requester 0.
- `cmd_rdy` held low for 5 cycles with `cmd_vld=1`: `cmd` stays bit-stable, no new `req_cmd_rdy`, `outstanding=1`.
- Requesters 2 then 1 issue reads; the head requester 2 holds `req_rsp_rdy=0` for 3 cycles: `rsp_rdy=0` for those cycles; responses are delivered to requester 2, then 1, never swapped.
- `rsp_vld=1` with the FIFO empty: `rsp_rdy=0`, `err_unexpected_rsp=1` from the next cycle, and it remains set after traffic resumes.
- `rst_n` asserted with 3 commands outstanding: all outputs take their reset values asynchronously; after release the first grant goes to requester 0.
